uart_rx_byte: RTL and testbench

// - 8N1 UART receiver, counterpart of the board's message-mode transmitter on the same serial link.
// - Oversamples rxd, validates start/stop bits and delivers each byte with a valid/ack handshake.
// - Flags framing errors and overrun (byte completes while the previous one is unacknowledged).
// - Feeds the host-side logic that compares and echoes received characters.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_byte_if.sv | 26 ++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_rx_byte.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t : receiver FSM states (PARITY is only used when UART_RX_PARITY_EN is defined)
//   DATA_BITS  : payload bits per character
//   baud_div() : clocks per oversample tick, clamped to at least 1
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK,
        DONE
    } rx_state_t;

    function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Consumer-side bundle of the UART byte receiver.
//   data       : last received byte, LSB first on the wire
//   data_valid : byte in data not yet acknowledged
//   data_ack   : consumer accepts data
//   frame_err  : one-cycle pulse on a bad stop (or parity) bit
//   overrun    : one-cycle pulse when a new byte replaces an unacknowledged one
//   busy       : receiver is somewhere other than IDLE
//
// Handshake: a byte is transferred on every clk where data_valid and data_ack
// are both 1. While data_valid is 1 and data_ack is 0, data holds still.
// data_ack while data_valid is 0 has no effect.
//
// Modports: master = receiver, slave = consumer.
interface uart_rx_byte_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 data_ack;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (output data, data_valid, frame_err, overrun, busy, input data_ack);
    modport slave  (input data, data_valid, frame_err, overrun, busy, output data_ack);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: tick is high for one clk out of every DIV clks.
//   clk, rst : system clock, synchronous active-high reset
//   restart  : forces the divider back to count 0 so the next tick is DIV clks away
//   tick     : one-clk pulse
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with valid/ack byte delivery, framing-error and overrun pulses.
// Optional even parity (8E1) when the macro UART_RX_PARITY_EN is defined.
//   clk, rst  : system clock, synchronous active-high reset
//   rxd       : asynchronous serial input, idle high
//   rx        : consumer bundle (data, data_valid, data_ack, frame_err, overrun, busy)
//   state_dbg : current FSM state
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    uart_rx_byte_if.master        rx,
    output rx_state_t             state_dbg
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);

    logic                 rx_meta, rx_s;
    rx_state_t            state, state_n;
    logic [SW-1:0]        scnt, scnt_n;
    logic [2:0]           bcnt, bcnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_r, data_n;
    logic                 valid_r, valid_n;
    logic                 fe_r, fe_n;
    logic                 ov_r, ov_n;
    logic                 tick, restart;

    // The divider is re-phased on the start edge so the half-bit start sample
    // and every later sample land in the middle of their bits.
    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            scnt    <= '0;
            bcnt    <= '0;
            shreg   <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            fe_r    <= 1'b0;
            ov_r    <= 1'b0;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
            state   <= state_n;
            scnt    <= scnt_n;
            bcnt    <= bcnt_n;
            shreg   <= shreg_n;
            data_r  <= data_n;
            valid_r <= valid_n;
            fe_r    <= fe_n;
            ov_r    <= ov_n;
        end
    end

    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        data_n  = data_r;
        valid_n = valid_r;
        fe_n    = 1'b0;
        ov_n    = 1'b0;
        restart = 1'b0;

        // Acknowledge first; a byte completing in the same clk overrides it below.
        if (valid_r && rx.data_ack) begin
            valid_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    scnt_n  = '0;
                    restart = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (scnt == S_MID) begin
                        scnt_n = '0;
                        bcnt_n = '0;
                        // A line that is high again at mid start bit was a glitch.
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (scnt == S_LAST) begin
                        scnt_n  = '0;
                        shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                        if (bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bcnt_n = bcnt + 1'b1;
                        end
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (scnt == S_LAST) begin
                        scnt_n = '0;
                        // Even parity: data bits plus parity bit must XOR to 0.
                        if ((^shreg) ^ rx_s) begin
                            fe_n    = 1'b1;
                            state_n = BREAK;
                        end else begin
                            state_n = STOP;
                        end
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (scnt == S_LAST) begin
                        scnt_n = '0;
                        if (rx_s) begin
                            state_n = DONE;
                        end else begin
                            fe_n    = 1'b1;
                            state_n = BREAK;
                        end
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end
            BREAK: begin
                // Only a return to idle-high re-arms start detection.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            DONE: begin
                data_n  = shreg;
                valid_n = 1'b1;
                ov_n    = valid_r && !rx.data_ack;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign rx.data       = data_r;
    assign rx.data_valid = valid_r;
    assign rx.frame_err  = fe_r;
    assign rx.overrun    = ov_r;
    assign rx.busy       = (state != IDLE);
    assign state_dbg     = state;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte at CLK_FREQ=1.6 MHz, BAUD=10k, OVERSAMPLE=16 (160 clks per bit).
// The model turns each transmitted frame into an expected event (byte, overrun
// or framing error) with its nominal arrival time; a monitor matches DUT events
// against that queue and checks the hold/ack rules on every clk.
module tb_uart_rx_byte;
    import uart_pkg::*;

    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD       = 10_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT        = CLK_FREQ / BAUD;
    localparam int LAT_TOL    = 3;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int NB     = 10;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int NB     = 9;
`endif

    // ---------------- clock / reset ----------------
    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      rxd = 1'b1;
    rx_state_t state_dbg;
    int        cyc = 0;

    uart_rx_byte_if rx ();

    uart_rx_byte #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx        (rx),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 80000 clks");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        n_total++;
        if (act >= exp - tol && act <= exp + tol) n_pass++;
        else $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    endtask

    // ---------------- scoreboard ----------------
    // Event encoding: {kind, byte}; kind 1 = byte delivered, 2 = framing error, 3 = overrun.
    logic [9:0] exp_q[$];
    int         exp_t_q[$];
    bit         model_pending = 1'b0;
    bit         mon_en = 1'b0;

    logic [9:0] ev, exp_ev;
    bit         has_ev;
    int         exp_t;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       ack_q = 1'b0;

    always @(posedge clk) ack_q <= rx.data_ack;

    initial begin
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                prev_valid = 1'b0;
                prev_data  = rx.data;
            end else begin
                has_ev = 1'b0;
                ev     = '0;
                if (rx.overrun) begin
                    ev = {2'd3, rx.data}; has_ev = 1'b1;
                end else if (rx.frame_err) begin
                    ev = {2'd2, 8'h00}; has_ev = 1'b1;
                end else if (rx.data_valid && (!prev_valid || rx.data != prev_data)) begin
                    ev = {2'd1, rx.data}; has_ev = 1'b1;
                end
                if (rx.frame_err || rx.overrun)
                    check("flag_exclusive", 32'(rx.frame_err & rx.overrun), 0);
                if (has_ev) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_event: got 0x%0h expected none", ev);
                    end else begin
                        exp_ev = exp_q.pop_front();
                        exp_t  = exp_t_q.pop_front();
                        check("event", 32'(ev), 32'(exp_ev));
                        check_near("event_time", cyc, exp_t, LAT_TOL);
                    end
                end
                if (prev_valid && !ack_q && !rx.overrun) begin
                    check("hold_valid", 32'(rx.data_valid), 1);
                    check("hold_data", 32'(rx.data), 32'(prev_data));
                end
                if (prev_valid && ack_q)
                    check("ack_clears", 32'(rx.data_valid), 0);
                prev_valid = rx.data_valid;
                prev_data  = rx.data;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (BIT) @(negedge clk);
    endtask

    // Sends one frame and records what the receiver must report for it.
    // Nominal event time: start edge + index of the deciding bit * BIT + half bit + sync/reg delay.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                              input int low_extra);
        int   start;
        logic par_ok;
        start  = cyc;
        par_ok = !PAR_EN || (((^b) ^ par_bit) == 1'b0);
        if (!par_ok) begin
            exp_q.push_back({2'd2, 8'h00});
            exp_t_q.push_back(start + 9 * BIT + BIT / 2 + 3);
        end else if (!stop_bit) begin
            exp_q.push_back({2'd2, 8'h00});
            exp_t_q.push_back(start + NB * BIT + BIT / 2 + 3);
        end else begin
            exp_q.push_back({model_pending ? 2'd3 : 2'd1, b});
            exp_t_q.push_back(start + NB * BIT + BIT / 2 + 3);
            model_pending = 1'b1;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR_EN) drive_bit(par_bit);
        drive_bit(stop_bit);
        if (!stop_bit) begin
            repeat (low_extra) @(negedge clk);
            rxd = 1'b1;
        end
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (rx.data_valid) break;
            @(negedge clk);
        end
        check(name, 32'(rx.data_valid), 1);
    endtask

    task automatic ack_pulse();
        rx.data_ack = 1'b1;
        @(negedge clk);
        rx.data_ack = 1'b0;
        model_pending = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rx.data_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(rx.data), 0);
        check("rst_valid", 32'(rx.data_valid), 0);
        check("rst_frame_err", 32'(rx.frame_err), 0);
        check("rst_overrun", 32'(rx.overrun), 0);
        check("rst_busy", 32'(rx.busy), 0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (20) @(negedge clk);

        // 0x50, acknowledged 5 clks after valid
        fork
            send_frame(8'h50, 1'b1, ^8'h50, 0);
            begin
                wait_valid("t1_valid_seen");
                check("t1_data", 32'(rx.data), 32'h50);
                check("t1_frame_err", 32'(rx.frame_err), 0);
                check("t1_overrun", 32'(rx.overrun), 0);
                repeat (5) @(negedge clk);
                ack_pulse();
            end
        join
        repeat (20) @(negedge clk);
        check("t1_valid_cleared", 32'(rx.data_valid), 0);

        // 0xA5 then 0x3C back-to-back, no ack in between
        send_frame(8'hA5, 1'b1, ^8'hA5, 0);
        send_frame(8'h3C, 1'b1, ^8'h3C, 0);
        check("t2_data", 32'(rx.data), 32'h3C);
        check("t2_valid", 32'(rx.data_valid), 1);
        ack_pulse();
        repeat (5) @(negedge clk);
        check("t2_valid_cleared", 32'(rx.data_valid), 0);

        // 0x55 with a low stop bit, line held low 300 clks from the stop bit
        repeat (20) @(negedge clk);
        send_frame(8'h55, 1'b0, ^8'h55, 300 - BIT);
        check("t3_busy_in_break", 32'(rx.busy), 1);
        check("t3_no_valid", 32'(rx.data_valid), 0);
        repeat (10) @(negedge clk);
        check("t3_idle_after_release", 32'(rx.busy), 0);
        check("t3_no_valid_after", 32'(rx.data_valid), 0);

        // 40-clk glitch on an idle line
        repeat (50) @(negedge clk);
        rxd = 1'b0;
        repeat (30) @(negedge clk);
        check("t4_busy_during_glitch", 32'(rx.busy), 1);
        repeat (10) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        check("t4_idle_after_glitch", 32'(rx.busy), 0);
        check("t4_no_valid", 32'(rx.data_valid), 0);

        // reset after bit 3 of a partial 0xAA, then 0x0F
        repeat (20) @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy_after_rst", 32'(rx.busy), 0);
        check("t5_data_after_rst", 32'(rx.data), 0);
        check("t5_state_after_rst", 32'(state_dbg), 32'(IDLE));
        repeat (100) @(negedge clk);
        fork
            send_frame(8'h0F, 1'b1, ^8'h0F, 0);
            begin
                wait_valid("t5_valid_seen");
                check("t5_data", 32'(rx.data), 32'h0F);
                repeat (5) @(negedge clk);
                ack_pulse();
            end
        join

`ifdef UART_RX_PARITY_EN
        // 0x07 with good parity (1), then with bad parity (0)
        repeat (20) @(negedge clk);
        fork
            send_frame(8'h07, 1'b1, 1'b1, 0);
            begin
                wait_valid("t6_valid_seen");
                check("t6_data", 32'(rx.data), 32'h07);
                repeat (5) @(negedge clk);
                ack_pulse();
            end
        join
        repeat (20) @(negedge clk);
        send_frame(8'h07, 1'b1, 1'b0, 0);
        repeat (20) @(negedge clk);
        check("t6_bad_parity_no_valid", 32'(rx.data_valid), 0);
`endif

        repeat (300) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
